// File: rtl/s3g_rx_pp_if.sv
// s3g_rx_pp_if
//   Bundles the byte-stream input, consumer handshake and committed-packet
//   read-out of the S3G packet receiver.
//   master : byte source / consumer side (drives rx_data, rx_done, pkt_ack,
//            buffer_addr; observes status, window and read data)
//   slave  : the receiver itself
//   ADDR_W and WINDOW must match the parameters of the attached s3g_rx_pp.
interface s3g_rx_pp_if #(
    parameter int ADDR_W = 6,
    parameter int WINDOW = 16
);
    logic [7:0]          rx_data;
    logic                rx_done;
    logic                pkt_ack;
    logic                packet_done;
    logic                err_crc;
    logic                err_len;
    logic                err_timeout;
    logic                overrun;
    logic                buffer_valid;
    logic [7:0]          payload_len;
    logic [8*WINDOW-1:0] win_data;
    logic [ADDR_W-1:0]   buffer_addr;
    logic [7:0]          buffer_data;

    modport master (
        output rx_data, rx_done, pkt_ack, buffer_addr,
        input  packet_done, err_crc, err_len, err_timeout, overrun,
               buffer_valid, payload_len, win_data, buffer_data
    );

    modport slave (
        input  rx_data, rx_done, pkt_ack, buffer_addr,
        output packet_done, err_crc, err_len, err_timeout, overrun,
               buffer_valid, payload_len, win_data, buffer_data
    );
endinterface

// File: rtl/s3g_rx_pp.sv
// s3g_rx_pp
//   S3G packet receiver: frames 0xD5 | len | payload | crc, checks the
//   Maxim CRC-8 and commits good packets atomically into a ping-pong bank
//   plus a flat window of the leading WINDOW bytes. The consumer reads the
//   committed packet while the next one fills the other bank.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    s3g_rx_pp_if.slave: rx_data/rx_done byte stream, pkt_ack release,
//          packet_done/err_crc/err_len/err_timeout/overrun pulses,
//          buffer_valid, payload_len, win_data, buffer_addr -> buffer_data
module s3g_rx_pp #(
    parameter int ADDR_W  = 6,
    parameter int WINDOW  = 16,
    parameter int TIMEOUT = 0,
    parameter int TO_W    = 24
) (
    input  logic      clk,
    input  logic      rst_n,
    s3g_rx_pp_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_LEN  = 2'd1,
        S_DATA = 2'd2,
        S_CRC  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                bank_sel_q, bank_sel_d;
    logic [7:0]          crc_q, crc_d;
    logic [7:0]          byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
    logic [7:0]          fill_len_q, fill_len_d;
    logic [8*WINDOW-1:0] fill_win_q, fill_win_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [8*WINDOW-1:0] win_data_q, win_data_d;
    logic [7:0]          payload_len_q, payload_len_d;
    logic                buffer_valid_q, buffer_valid_d;
    logic                packet_done_q, packet_done_d;
    logic                err_crc_q, err_crc_d;
    logic                err_len_q, err_len_d;
    logic                err_timeout_q, err_timeout_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          buffer_data_q, buffer_data_d;

    logic                commit;
    logic                timeout_hit;
    logic                mem_we;
    logic [ADDR_W:0]     mem_waddr;

    // Both banks live in one array; the MSB of the index selects the bank.
    logic [7:0] mem [2*DEPTH];

    // Maxim/iButton CRC-8 (reflected poly 0x8C), one byte per call.
    function automatic logic [7:0] crc8_next(input logic [7:0] d, input logic [7:0] c);
        logic [7:0] r;
        r = c ^ d;
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        state_d        = state_q;
        bank_sel_d     = bank_sel_q;
        crc_d          = crc_q;
        byte_cnt_d     = byte_cnt_q;
        fill_addr_d    = fill_addr_q;
        fill_len_d     = fill_len_q;
        fill_win_d     = fill_win_q;
        to_cnt_d       = to_cnt_q;
        win_data_d     = win_data_q;
        payload_len_d  = payload_len_q;
        buffer_valid_d = buffer_valid_q;
        packet_done_d  = 1'b0;
        err_crc_d      = 1'b0;
        err_len_d      = 1'b0;
        err_timeout_d  = 1'b0;
        overrun_d      = 1'b0;
        commit         = 1'b0;
        timeout_hit    = 1'b0;
        mem_we         = 1'b0;
        // Fill bank is always the one not currently being read.
        mem_waddr      = {~bank_sel_q, fill_addr_q};
        buffer_data_d  = mem[{bank_sel_q, bus.buffer_addr}];

        if (TIMEOUT > 0) begin
            if (bus.rx_done) begin
                to_cnt_d = '0;
            end else if (state_q != S_INIT) begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
            // A byte arriving in the expiry cycle wins over the timeout.
            timeout_hit = (state_q != S_INIT) && !bus.rx_done &&
                          (to_cnt_q == TO_W'(TIMEOUT - 1));
        end

        case (state_q)
            S_INIT: begin
                if (bus.rx_done && bus.rx_data == 8'hD5) begin
                    state_d     = S_LEN;
                    fill_addr_d = '0;
                    fill_win_d  = '0;
                    crc_d       = '0;
                end
            end
            S_LEN: begin
                if (bus.rx_done) begin
                    fill_len_d = bus.rx_data;
                    byte_cnt_d = bus.rx_data;
                    if (32'(bus.rx_data) > DEPTH) begin
                        err_len_d = 1'b1;
                        state_d   = S_INIT;
                    end else if (bus.rx_data == 8'd0) begin
                        state_d = S_CRC;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bus.rx_done) begin
                    mem_we = 1'b1;
                    for (int unsigned i = 0; i < WINDOW; i++) begin
                        if (i == 32'(fill_addr_q)) begin
                            fill_win_d[8*i +: 8] = bus.rx_data;
                        end
                    end
                    crc_d       = crc8_next(bus.rx_data, crc_q);
                    fill_addr_d = fill_addr_q + ADDR_W'(1);
                    byte_cnt_d  = byte_cnt_q - 8'd1;
                    if (byte_cnt_q == 8'd1) begin
                        state_d = S_CRC;
                    end
                end
            end
            S_CRC: begin
                if (bus.rx_done) begin
                    state_d = S_INIT;
                    if (bus.rx_data == crc_q) begin
                        commit = 1'b1;
                    end else begin
                        err_crc_d = 1'b1;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase

        if (timeout_hit) begin
            state_d       = S_INIT;
            err_timeout_d = 1'b1;
            to_cnt_d      = '0;
        end

        // A commit outranks a simultaneous pkt_ack: the new packet stays valid.
        if (commit) begin
            bank_sel_d     = ~bank_sel_q;
            win_data_d     = fill_win_q;
            payload_len_d  = fill_len_q;
            buffer_valid_d = 1'b1;
            packet_done_d  = 1'b1;
            overrun_d      = buffer_valid_q && !bus.pkt_ack;
        end else if (bus.pkt_ack) begin
            buffer_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_INIT;
            bank_sel_q     <= 1'b0;
            crc_q          <= '0;
            byte_cnt_q     <= '0;
            fill_addr_q    <= '0;
            fill_len_q     <= '0;
            fill_win_q     <= '0;
            to_cnt_q       <= '0;
            win_data_q     <= '0;
            payload_len_q  <= '0;
            buffer_valid_q <= 1'b0;
            packet_done_q  <= 1'b0;
            err_crc_q      <= 1'b0;
            err_len_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
            overrun_q      <= 1'b0;
            buffer_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            bank_sel_q     <= bank_sel_d;
            crc_q          <= crc_d;
            byte_cnt_q     <= byte_cnt_d;
            fill_addr_q    <= fill_addr_d;
            fill_len_q     <= fill_len_d;
            fill_win_q     <= fill_win_d;
            to_cnt_q       <= to_cnt_d;
            win_data_q     <= win_data_d;
            payload_len_q  <= payload_len_d;
            buffer_valid_q <= buffer_valid_d;
            packet_done_q  <= packet_done_d;
            err_crc_q      <= err_crc_d;
            err_len_q      <= err_len_d;
            err_timeout_q  <= err_timeout_d;
            overrun_q      <= overrun_d;
            buffer_data_q  <= buffer_data_d;
        end
    end

    assign bus.packet_done  = packet_done_q;
    assign bus.err_crc      = err_crc_q;
    assign bus.err_len      = err_len_q;
    assign bus.err_timeout  = err_timeout_q;
    assign bus.overrun      = overrun_q;
    assign bus.buffer_valid = buffer_valid_q;
    assign bus.payload_len  = payload_len_q;
    assign bus.win_data     = win_data_q;
    assign bus.buffer_data  = buffer_data_q;
endmodule
